keccak_chi_round_ctrl: RTL and testbench
========================================

# keccak_chi_round_ctrl

Sequencing controller for the masked Keccak-f[200] permutation. It drives a bank of `SBOX_PAR` DOM chi S-box instances plus the per-share linear layer (theta/rho/pi) and a share-0 iota XOR. It counts rounds and chi batches, gates every chi issue on fresh-randomness availability, tracks the S-box pipeline latency to produce write-back strobes, and supplies the round constant. It carries no share data: the state register, linear layer, S-boxes and PRNG-to-S-box randomness bus are outside the block and obey its strobes.

## Interface
- `ROUNDS`, 18: rounds per permutation (1..18).
- `ROWS`, 40: 5-bit chi rows in the state.
- `SBOX_PAR`, 8: S-box instances; must divide `ROWS`. Batches per round `NB = ROWS/SBOX_PAR` (default 5).
- `CHI_LATENCY`, 1: S-box issue-to-result cycles (1 or 2).
- `ClkxCI` input 1: clock, rising edge.
- `RstxRI` input 1: asynchronous, active-high reset.
- `StartxSI` input 1: request a permutation; accepted when `ReadyxSO` is high.
- `ReadyxSO` output 1: controller idle.
- `DonexSO` output 1: one-cycle pulse, permutation complete.
- `LinEnxSO` output 1: state register loads the linear-layer output this cycle.
- `RandValidxSI` input 1: PRNG presents fresh randomness for one batch.
- `RandReadyxSO` output 1: randomness consumed this cycle; equals chi issue.
- `ChiIssuexSO` output 1: S-box inputs for batch `ChiIssueBatchxDO` are valid.
- `ChiIssueBatchxDO` output `clog2(NB)`: batch being issued.
- `ChiWrxSO` output 1: S-box outputs written back to rows of `ChiWrBatchxDO`.
- `ChiWrBatchxDO` output `clog2(NB)`: batch being written.
- `IotaRCxDO` output 8: round-constant byte, valid while `ChiIssuexSO` is high and `ChiIssueBatchxDO == 0`; 0 otherwise.
- `RoundxDO` output 5: current round index.

## Operation
- **States:** IDLE, LIN, ISSUE, DRAIN, DONE.
- **IDLE:** `ReadyxSO` is 1. `StartxSI` goes to LIN with round 0.
- **LIN:** one cycle with `LinEnxSO` = 1, then ISSUE with batch 0.
- **ISSUE:**
  - `ChiIssuexSO = RandReadyxSO = RandValidxSI`. The batch counter increments only on issue.
  - If `RandValidxSI` is 0, this is a stall cycle: the issue outputs hold and nothing is consumed.
  - After issuing batch `NB-1`, go to DRAIN.
- **Write-back pipeline:** a `CHI_LATENCY`-deep shift register carries {issue, batch}. It advances every cycle, stalls included, so `ChiWrxSO`/`ChiWrBatchxDO` are the issue signals delayed by exactly `CHI_LATENCY`.
- **DRAIN:** wait until the pipeline is empty, i.e. the write of batch `NB-1` has been seen.
  - If `RoundxDO == ROUNDS-1`, go to DONE.
  - Otherwise increment the round and go to LIN.
- **DONE:** one cycle with `DonexSO` = 1, then IDLE.
- **Round-constant bytes,** rounds 0..17: 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80 (hex). The datapath XORs the byte into share 0, lane (0,0).
- **Ignored starts:** `StartxSI` outside IDLE is ignored; this includes the DONE cycle.
- **Arithmetic:** counters are unsigned. Batch wraps to 0 at each LIN; round never exceeds `ROUNDS-1`.
- **Output zeroing:** all strobes and `IotaRCxDO` are 0 in any state where they are not defined above.

## Timing
- **Reset:** `RstxRI` high asynchronously forces IDLE, counters to 0 and the write-back pipeline to empty.
  - `ReadyxSO` is 1; `DonexSO`, `LinEnxSO`, `RandReadyxSO`, `ChiIssuexSO`, `ChiWrxSO` are 0; all buses are 0.
  - A reset mid-permutation discards in-flight writes with no `ChiWrxSO` afterwards. The next start begins again at round 0.
- **Cycle numbering:** the start is accepted at edge 0, and cycles are numbered after that edge.
- **Round schedule without stalls** (`NB`=5, `CHI_LATENCY`=1, round r):
  - LIN at cycle 1+7r.
  - Issues of batches 0..4 at cycles 2+7r..6+7r.
  - Writes at cycles 3+7r..7+7r.
  - DRAIN overlaps the last write, so the next LIN is at 8+7r.
- **Per-round length:** 2+NB+`CHI_LATENCY`-1 cycles (7 at defaults), plus one per stall cycle.
- **Completion at defaults:** `DonexSO` at cycle 127 and `ReadyxSO` high again at cycle 128. A new start can be accepted at edge 128.
- **Consecutive issues:** two consecutive issues never reuse randomness; each consumes one `RandValidxSI`/`RandReadyxSO` handshake.

## Test plan
- **Basic run:** reset, then `StartxSI` pulse with `RandValidxSI` held at 1 → `LinEnxSO` at cycles 1, 8, 15, …; 90 issues and 90 writes; `DonexSO` only at cycle 127; `ReadyxSO` at 128.
- **Round constants:** check `IotaRCxDO` on each batch-0 issue → sequence 01, 82, 8A, 00, …, 80. It is 0 on every other cycle.
- **Randomness stall:** hold `RandValidxSI` low for 3 cycles during round 0, batch 2 → batch index holds; the batch-1 write still occurs at cycle 4; round 0 ends 3 cycles later; `DonexSO` at cycle 130.
- **Latency 2:** `CHI_LATENCY`=2 → each write lags its issue by 2 cycles; round length 8; `DonexSO` at cycle 145.
- **Ignored start:** assert `StartxSI` during ISSUE and during DONE → no effect; exactly one `DonexSO` per accepted start.
- **Mid-run reset:** assert `RstxRI` at cycle 40 (round 5) → all strobes 0 immediately and `ReadyxSO` = 1; a subsequent start replays from round 0 with `IotaRCxDO` = 01.

Source files
------------

// File: rtl/keccak_chi_round_ctrl.sv
// keccak_chi_round_ctrl: sequencing controller for a masked Keccak-f[200] core.
// It counts rounds and chi batches and only issues a chi batch when fresh
// randomness is available. It tracks the S-box latency to produce write-back
// strobes and supplies the iota round-constant byte. No share data passes through it.
//
// Ports:
//   ClkxCI            clock, rising edge
//   RstxRI            asynchronous active-high reset
//   StartxSI          start a permutation (accepted while ReadyxSO)
//   ReadyxSO          controller idle
//   DonexSO           one-cycle completion pulse
//   LinEnxSO          state register loads the linear-layer output
//   RandValidxSI      PRNG offers randomness for one batch
//   RandReadyxSO      randomness consumed (equals chi issue)
//   ChiIssuexSO       S-box inputs of ChiIssueBatchxDO are valid
//   ChiIssueBatchxDO  batch being issued
//   ChiWrxSO          S-box outputs written back to ChiWrBatchxDO
//   ChiWrBatchxDO     batch being written
//   IotaRCxDO         round constant on batch-0 issue, else 0
//   RoundxDO          current round index
module keccak_chi_round_ctrl #(
  parameter int unsigned ROUNDS      = 18,
  parameter int unsigned ROWS        = 40,
  parameter int unsigned SBOX_PAR    = 8,
  parameter int unsigned CHI_LATENCY = 1,
  localparam int unsigned NB = ROWS / SBOX_PAR,
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          ClkxCI,
  input  logic          RstxRI,
  input  logic          StartxSI,
  output logic          ReadyxSO,
  output logic          DonexSO,
  output logic          LinEnxSO,
  input  logic          RandValidxSI,
  output logic          RandReadyxSO,
  output logic          ChiIssuexSO,
  output logic [BW-1:0] ChiIssueBatchxDO,
  output logic          ChiWrxSO,
  output logic [BW-1:0] ChiWrBatchxDO,
  output logic [7:0]    IotaRCxDO,
  output logic [4:0]    RoundxDO
);

  localparam int unsigned RW = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LIN   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [BW-1:0] batch_q, batch_d;

  logic          ready, done, lin_en, issue;
  logic [BW-1:0] issue_batch_pipe;
  logic          last_wr;

  // write-back pipeline: one {valid, batch} entry per cycle of S-box latency
  logic          wr_v_q [CHI_LATENCY];
  logic [BW-1:0] wr_b_q [CHI_LATENCY];

  // Keccak-f[200] iota byte for each round
  function automatic logic [7:0] round_const(input logic [RW-1:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      5'd0:  rc = 8'h01;
      5'd1:  rc = 8'h82;
      5'd2:  rc = 8'h8A;
      5'd3:  rc = 8'h00;
      5'd4:  rc = 8'h8B;
      5'd5:  rc = 8'h01;
      5'd6:  rc = 8'h81;
      5'd7:  rc = 8'h09;
      5'd8:  rc = 8'h8A;
      5'd9:  rc = 8'h88;
      5'd10: rc = 8'h09;
      5'd11: rc = 8'h0A;
      5'd12: rc = 8'h8B;
      5'd13: rc = 8'h8B;
      5'd14: rc = 8'h89;
      5'd15: rc = 8'h03;
      5'd16: rc = 8'h02;
      5'd17: rc = 8'h80;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // the last write of a round has reached the output stage
  assign last_wr = wr_v_q[CHI_LATENCY-1] && (wr_b_q[CHI_LATENCY-1] == BW'(NB - 1));

  // next-state and strobe decode
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    batch_d = batch_q;
    ready   = 1'b0;
    done    = 1'b0;
    lin_en  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (StartxSI) begin
          state_d = ST_LIN;
          round_d = '0;
        end
      end
      ST_LIN: begin
        lin_en  = 1'b1;
        batch_d = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // a cycle without randomness is a stall: the batch counter holds
        issue = RandValidxSI;
        if (RandValidxSI) begin
          if (batch_q == BW'(NB - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            batch_d = batch_q + BW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (last_wr) begin
          if (round_q == RW'(ROUNDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + RW'(1);
            state_d = ST_LIN;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      batch_q <= batch_d;
    end
  end

  assign issue_batch_pipe = issue ? batch_q : '0;

  // latency pipeline advances every cycle, stalls included
  for (genvar g = 0; g < int'(CHI_LATENCY); g++) begin : g_wr_pipe
    if (g == 0) begin : g_first
      always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
          wr_v_q[0] <= 1'b0;
          wr_b_q[0] <= '0;
        end else begin
          wr_v_q[0] <= issue;
          wr_b_q[0] <= issue_batch_pipe;
        end
      end
    end else begin : g_next
      always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
          wr_v_q[g] <= 1'b0;
          wr_b_q[g] <= '0;
        end else begin
          wr_v_q[g] <= wr_v_q[g-1];
          wr_b_q[g] <= wr_b_q[g-1];
        end
      end
    end
  end

  assign ReadyxSO         = ready;
  assign DonexSO          = done;
  assign LinEnxSO         = lin_en;
  assign ChiIssuexSO      = issue;
  assign RandReadyxSO     = issue;
  assign ChiIssueBatchxDO = batch_q;
  assign ChiWrxSO         = wr_v_q[CHI_LATENCY-1];
  assign ChiWrBatchxDO    = wr_b_q[CHI_LATENCY-1];
  assign IotaRCxDO        = (issue && (batch_q == '0)) ? round_const(round_q) : 8'h00;
  assign RoundxDO         = round_q;

endmodule

// File: tb/tb_keccak_chi_round_ctrl.sv
// Scoreboard bench for keccak_chi_round_ctrl. Two instances run side by side:
// one with CHI_LATENCY=1 and one with CHI_LATENCY=2. They share the same start,
// randomness and reset stimulus. Expected per-cycle events are queued when a
// start is issued, and a negedge monitor pops and compares them.
module tb_keccak_chi_round_ctrl;

  typedef struct {
    int kind;   // 0 lin, 1 issue, 2 rc, 3 write, 4 done
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst, start, rv;
  always #5 clk = ~clk;

  logic       rdy0, done0, lin0, rr0, iss0, wr0;
  logic [2:0] ib0, wb0;
  logic [7:0] rc0;
  logic [4:0] rnd0;
  logic       rdy1, done1, lin1, rr1, iss1, wr1;
  logic [2:0] ib1, wb1;
  logic [7:0] rc1;
  logic [4:0] rnd1;

  keccak_chi_round_ctrl #(.CHI_LATENCY(1)) dut0 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .ReadyxSO(rdy0), .DonexSO(done0),
    .LinEnxSO(lin0), .RandValidxSI(rv), .RandReadyxSO(rr0), .ChiIssuexSO(iss0),
    .ChiIssueBatchxDO(ib0), .ChiWrxSO(wr0), .ChiWrBatchxDO(wb0), .IotaRCxDO(rc0),
    .RoundxDO(rnd0));

  keccak_chi_round_ctrl #(.CHI_LATENCY(2)) dut1 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .ReadyxSO(rdy1), .DonexSO(done1),
    .LinEnxSO(lin1), .RandValidxSI(rv), .RandReadyxSO(rr1), .ChiIssuexSO(iss1),
    .ChiIssueBatchxDO(ib1), .ChiWrxSO(wr1), .ChiWrBatchxDO(wb1), .IotaRCxDO(rc1),
    .RoundxDO(rnd1));

  logic [7:0] rct [18] = '{8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
                           8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80};

  ev_t q0[$];
  ev_t q1[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  ncyc     = 0;
  int  base     = 0;
  int  rel;

  always @(posedge clk) ncyc = ncyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "lin";
      1: return "issue";
      2: return "iota_rc";
      3: return "write";
      default: return "done";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int qsz(input int inst);
    if (inst == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic ev_t qfront(input int inst);
    if (inst == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int inst);
    if (inst == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic qpush(input int inst, input int kind, input int cyc, input int val);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.val = val;
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected schedule of one permutation. An optional stall of stall_len cycles
  // precedes the issue of round 0, batch 2. Issue events encode
  // 32*ChiIssue + 16*RandReady + batch. done_cyc is the hand-computed DONE cycle.
  task automatic gen(input int inst, input int lat, input int stall_len, input int done_cyc);
    int ev [5][256];
    int t;
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 256; c++) ev[k][c] = -1;
    t = 1;
    for (int r = 0; r < 18; r++) begin
      ev[0][t] = 0;
      t++;
      for (int b = 0; b < 5; b++) begin
        if (r == 0 && b == 2) t += stall_len;
        ev[1][t] = 48 + b;
        if (b == 0) ev[2][t] = int'(rct[r]);
        ev[3][t + lat] = b;
        t++;
      end
      t += lat;
    end
    ev[4][done_cyc] = 0;
    for (int c = 1; c < 256; c++)
      for (int k = 0; k < 5; k++)
        if (ev[k][c] >= 0) qpush(inst, k, c, ev[k][c]);
  endtask

  task automatic mon(input int inst, input logic l, input logic is, input logic r,
                     input logic [2:0] ib, input logic [7:0] rc, input logic w,
                     input logic [2:0] wb, input logic d);
    bit  obs [5];
    int  val [5];
    bit  hit;
    ev_t e;
    obs[0] = l;               val[0] = 0;
    obs[1] = is || r;         val[1] = (is ? 32 : 0) + (r ? 16 : 0) + int'(ib);
    obs[2] = (rc != 8'h00) || (is && ib == 3'd0); val[2] = int'(rc);
    obs[3] = w;               val[3] = int'(wb);
    obs[4] = d;               val[4] = 0;
    while (qsz(inst) > 0 && qfront(inst).cyc < rel) begin
      e = qfront(inst);
      n_checks++;
      $display("FAIL dut%0d %s missing at cycle %0d (now %0d)", inst, kname(e.kind), e.cyc, rel);
      qpop(inst);
    end
    for (int k = 0; k < 5; k++) begin
      hit = 1'b0;
      if (qsz(inst) > 0) begin
        e = qfront(inst);
        hit = (e.cyc == rel) && (e.kind == k);
      end
      if (obs[k] || hit) begin
        n_checks++;
        if (!hit)
          $display("FAIL dut%0d %s unexpected at cycle %0d value %0d", inst, kname(k), rel, val[k]);
        else if (!obs[k])
          $display("FAIL dut%0d %s absent at cycle %0d expected %0d", inst, kname(k), rel, e.val);
        else if (val[k] != e.val)
          $display("FAIL dut%0d %s at cycle %0d got %0d expected %0d", inst, kname(k), rel, val[k], e.val);
        else
          n_pass++;
        if (hit) qpop(inst);
      end
    end
  endtask

  // monitor: cycle numbering restarts at each accepted start
  always @(negedge clk) begin
    if (!rst) begin
      if (start && rdy0 && rdy1) begin
        base = ncyc + 1;
      end else begin
        rel = ncyc - base + 1;
        mon(0, lin0, iss0, rr0, ib0, rc0, wr0, wb0, done0);
        mon(1, lin1, iss1, rr1, ib1, rc1, wr1, wb1, done1);
      end
    end
  end

  // start both instances; returns #1 into cycle 1
  task automatic start_perm(input int stall_len, input int d0, input int d1);
    @(posedge clk); #1;
    start = 1'b1;
    gen(0, 1, stall_len, d0);
    gen(1, 2, stall_len, d1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && rdy0 && rdy1) break;
    end
    chk("dut0_pending_events", q0.size(), 0);
    chk("dut1_pending_events", q1.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready0"}, int'(rdy0), 1);
    chk({tag, "_ready1"}, int'(rdy1), 1);
    chk({tag, "_strobes0"}, int'({done0, lin0, rr0, iss0, wr0}), 0);
    chk({tag, "_strobes1"}, int'({done1, lin1, rr1, iss1, wr1}), 0);
    chk({tag, "_rc0"}, int'(rc0), 0);
    chk({tag, "_wrbatch1"}, int'(wb1), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rv = 1'b1;
    #12;
    chk_idle("reset");
    chk("reset_round0", int'(rnd0), 0);
    chk("reset_batch0", int'(ib0), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic run, randomness always available
    start_perm(0, 127, 145);
    repeat (127) @(posedge clk);
    #1;
    chk("ready0_at_128", int'(rdy0), 1);
    wait_idle();

    // three stall cycles before round 0, batch 2
    start_perm(3, 130, 148);
    repeat (3) @(posedge clk);
    #1 rv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rv = 1'b1;
    wait_idle();

    // starts during ISSUE (cycle 20) and during the DONE cycle of dut0 (127)
    start_perm(0, 127, 145);
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (106) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // reset at cycle 40: strobes drop at once, in-flight writes discarded
    start_perm(0, 127, 145);
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_idle("midreset");
    q0.delete();
    q1.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // full replay from round 0
    start_perm(0, 127, 145);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
